jelly3_axi4l_register_mode: RTL and testbench
=============================================

# jelly3_axi4l_register_mode

Parametrised AXI4-Lite register file with a per-register access mode (read/write, read-only, write-1-to-clear, write-pulse), byte-strobe writes, independent AW/W acceptance and SLVERR on unmapped indices. It sits behind a `jelly3_axi4l_addr_decoder` output slot and replaces the plain RW-only register bank. It exports control values, pulse strobes and an interrupt to fabric logic, and imports status from fabric logic.

## Interface
- `NUM`, 8: number of 32-bit-aligned registers; index = `awaddr/araddr[2 +: $clog2(NUM)]`.
- `DATA_BITS`, 32: register width; `STRB_BITS = DATA_BITS/8`.
- `ADDR_BITS`, 40: AXI address width.
- `MODE`, all 0: `[NUM-1:0][1:0]` per-register mode; 0 = RW, 1 = RO, 2 = W1C, 3 = PULSE.
- `INIT`, all 0: `[NUM-1:0][DATA_BITS-1:0]` reset value for RW registers.
- `reset`  in  1  synchronous, active-high reset.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `s_axi4l_aw{addr,prot,valid,ready}`, `s_axi4l_w{data,strb,valid,ready}`, `s_axi4l_b{resp,valid,ready}`, `s_axi4l_ar{addr,prot,valid,ready}`, `s_axi4l_r{data,resp,valid,ready}`: AXI4-Lite slave, widths per parameters; `prot` ignored.
- `value`  out  `[NUM][DATA_BITS]`  current content of every register (RO entries read as `ro_value`).
- `ro_value`  in  `[NUM][DATA_BITS]`  status inputs, used only by RO registers.
- `w1c_set`  in  `[NUM][DATA_BITS]`  per-bit set pulses, used only by W1C registers.
- `pulse`  out  `[NUM][DATA_BITS]`  one-cycle strobes, used only by PULSE registers.
- `irq`  out  1  OR of all bits of all W1C registers.

## Operation
- Write channel: AW and W are accepted independently and held. `awready = !reset && !aw_held && !bvalid`; `wready = !reset && !w_held && !bvalid`.
- A write executes on the first edge at which both AW and W are held, counting the edge that captures them. On that same edge `bvalid` rises and both held flags clear.
- Byte lanes with `wstrb[k]=0` are untouched for every mode.
- Mode RW: enabled byte lanes are replaced with `wdata`.
- Mode RO: writes ignored; `bresp=OKAY`.
- Mode W1C: an enabled bit is cleared when the written bit is 1. Every cycle, `w1c_set` bits are ORed in. When set and clear coincide on a bit, the set wins.
- Mode PULSE: `pulse[i]` bits for enabled lanes equal the written data for exactly one cycle, otherwise 0. Reads return 0.
- Index `>= NUM` (non-power-of-two `NUM`): write discarded and `bresp=SLVERR` (2'b10); read returns `rdata=0`, `rresp=SLVERR`.
- Read channel: `arready = !reset && !rvalid`. On the AR handshake edge, `rdata`/`rresp` are registered and `rvalid` rises.
- Read and write channels are independent; both may complete in the same cycle. A same-cycle read of a register being written returns the pre-write value.
- `irq` is registered from the W1C contents.

## Timing
- Reset values: `value` = `INIT` (RW), 0 (W1C, PULSE); `pulse`=0, `irq`=0, `bvalid`=0, `rvalid`=0, `bresp`=0, `rresp`=0, `rdata`=0; all held flags cleared; all readies 0 while `reset` is high.
- Reset mid-transaction aborts it: held AW/W are discarded and no response is issued.
- Write latency: AW+W handshake at edge N gives register update and `bvalid=1` from edge N. `value` reflects the write in cycle N+1; `pulse` is high during cycle N..N+1 only.
- Split write: AW at edge N, W at edge M>N gives execution at edge M. At most one write is outstanding; a second AW/W is not accepted until the B handshake.
- `bvalid`/`bresp` hold until `bready`; `rvalid`/`rdata`/`rresp` hold until `rready`. Back-to-back reads sustain one read per 2 cycles.
- `irq` follows W1C contents one cycle later.

## Test plan
- Reset with `INIT[0]=32'h1234_5678`, `MODE[0]=RW` -> `value[0]=32'h1234_5678`; read of 0x00 returns it with `rresp=0`.
- Write 0x00 `wdata=32'hAABB_CCDD`, `wstrb=4'b0101`, W driven 3 cycles after AW -> `value[0]=32'h12BB_56DD`; single `bvalid` one cycle after W; `bready` low for 4 cycles keeps `bvalid` and `bresp=0` stable.
- `MODE[2]=W1C`: pulse `w1c_set[2]=32'h0000_0011` -> `irq=1` next cycle. Write 0x08 with `32'h0000_0001` while `w1c_set[2]=32'h1` the same cycle -> bit0 stays 1 and bit4 stays 1. Write `32'h11` -> register 0 and `irq=0`.
- `MODE[3]=PULSE`: write 0x0C with `32'h8000_0001` -> `pulse[3]=32'h8000_0001` for exactly one cycle; read of 0x0C returns 0.
- `MODE[1]=RO` with `ro_value[1]=32'hDEAD_BEEF`: write 0x04 -> `bresp=0` and value unchanged; read returns `32'hDEAD_BEEF`. With `NUM=6`, read and write of 0x18 -> SLVERR and `rdata=0`.
- Assert `reset` one cycle after an AW-only handshake, then write via W -> no `bvalid` from the aborted write; the post-reset transaction completes normally.

Source files
------------

// File: rtl/jelly3_axi4l_register_mode.sv
// AXI4-Lite register file with per-register access modes (RW, RO, W1C, PULSE).
// AW and W are captured independently; a write executes once both are present.
module jelly3_axi4l_register_mode #(
  parameter int                            NUM       = 8,
  parameter int                            DATA_BITS = 32,
  parameter int                            ADDR_BITS = 40,
  parameter logic [NUM-1:0][1:0]           MODE      = '0,
  parameter logic [NUM-1:0][DATA_BITS-1:0] INIT      = '0
) (
  input  logic                            reset,
  input  logic                            clk,
  input  logic [ADDR_BITS-1:0]            s_axi4l_awaddr,
  input  logic [2:0]                      s_axi4l_awprot,
  input  logic                            s_axi4l_awvalid,
  output logic                            s_axi4l_awready,
  input  logic [DATA_BITS-1:0]            s_axi4l_wdata,
  input  logic [DATA_BITS/8-1:0]          s_axi4l_wstrb,
  input  logic                            s_axi4l_wvalid,
  output logic                            s_axi4l_wready,
  output logic [1:0]                      s_axi4l_bresp,
  output logic                            s_axi4l_bvalid,
  input  logic                            s_axi4l_bready,
  input  logic [ADDR_BITS-1:0]            s_axi4l_araddr,
  input  logic [2:0]                      s_axi4l_arprot,
  input  logic                            s_axi4l_arvalid,
  output logic                            s_axi4l_arready,
  output logic [DATA_BITS-1:0]            s_axi4l_rdata,
  output logic [1:0]                      s_axi4l_rresp,
  output logic                            s_axi4l_rvalid,
  input  logic                            s_axi4l_rready,
  output logic [NUM-1:0][DATA_BITS-1:0]   value,
  input  logic [NUM-1:0][DATA_BITS-1:0]   ro_value,
  input  logic [NUM-1:0][DATA_BITS-1:0]   w1c_set,
  output logic [NUM-1:0][DATA_BITS-1:0]   pulse,
  output logic                            irq
);

  localparam int STRB_BITS = DATA_BITS / 8;
  localparam int IDX_BITS  = (NUM > 1) ? $clog2(NUM) : 1;

  localparam logic [1:0] MODE_RW    = 2'd0;
  localparam logic [1:0] MODE_RO    = 2'd1;
  localparam logic [1:0] MODE_W1C   = 2'd2;
  localparam logic [1:0] MODE_PULSE = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                          awHeld_q, wHeld_q;
  logic [IDX_BITS-1:0]           awIdx_q;
  logic [DATA_BITS-1:0]          wData_q;
  logic [STRB_BITS-1:0]          wStrb_q;
  logic                          bValid_q, rValid_q;
  logic [1:0]                    bResp_q, rResp_q;
  logic [DATA_BITS-1:0]          rData_q;
  logic [NUM-1:0][DATA_BITS-1:0] reg_q, reg_d;
  logic [NUM-1:0][DATA_BITS-1:0] pulse_q, pulse_d;
  logic                          irq_q, irq_d;

  logic                          awHs, wHs, arHs, awHave, wHave, wrExec, wrOk, hit;
  logic [IDX_BITS-1:0]           awIdxIn, arIdxIn, wrIdx;
  logic [DATA_BITS-1:0]          wrData, wrMask, rdData;
  logic [STRB_BITS-1:0]          wrStrb;
  logic [1:0]                    rdResp;
  logic                          unused_bits;

  assign unused_bits = ^{s_axi4l_awprot, s_axi4l_arprot, s_axi4l_awaddr, s_axi4l_araddr, ro_value, w1c_set};

  assign s_axi4l_awready = !reset && !awHeld_q && !bValid_q;
  assign s_axi4l_wready  = !reset && !wHeld_q && !bValid_q;
  assign s_axi4l_arready = !reset && !rValid_q;

  assign awHs    = s_axi4l_awvalid && s_axi4l_awready;
  assign wHs     = s_axi4l_wvalid && s_axi4l_wready;
  assign arHs    = s_axi4l_arvalid && s_axi4l_arready;
  assign awIdxIn = s_axi4l_awaddr[2 +: IDX_BITS];
  assign arIdxIn = s_axi4l_araddr[2 +: IDX_BITS];

  // A write fires on the edge where address and data are both available,
  // whether they were held from earlier edges or arrive on this one.
  assign awHave = awHeld_q || awHs;
  assign wHave  = wHeld_q || wHs;
  assign wrExec = awHave && wHave;
  assign wrIdx  = awHs ? awIdxIn : awIdx_q;
  assign wrData = wHs ? s_axi4l_wdata : wData_q;
  assign wrStrb = wHs ? s_axi4l_wstrb : wStrb_q;
  assign wrOk   = int'(wrIdx) < NUM;

  always_comb begin
    wrMask = '0;
    for (int k = 0; k < STRB_BITS; k++) wrMask[8*k +: 8] = {8{wrStrb[k]}};
  end

  // W1C set pulses take priority over a same-cycle clear of the same bit.
  always_comb begin
    reg_d   = reg_q;
    pulse_d = '0;
    hit     = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      hit = wrExec && wrOk && (int'(wrIdx) == i);
      case (MODE[i])
        MODE_RW:    if (hit) reg_d[i] = (reg_q[i] & ~wrMask) | (wrData & wrMask);
        MODE_W1C:   reg_d[i] = (reg_q[i] & ~(hit ? (wrData & wrMask) : '0)) | w1c_set[i];
        MODE_PULSE: begin
          reg_d[i] = '0;
          if (hit) pulse_d[i] = wrData & wrMask;
        end
        default:    reg_d[i] = '0;
      endcase
    end
  end

  always_comb begin
    value = '0;
    irq_d = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      case (MODE[i])
        MODE_RO:    value[i] = ro_value[i];
        MODE_PULSE: value[i] = '0;
        default:    value[i] = reg_q[i];
      endcase
      if (MODE[i] == MODE_W1C) irq_d = irq_d | (|reg_q[i]);
    end
  end

  always_comb begin
    rdData = '0;
    rdResp = RESP_SLVERR;
    if (int'(arIdxIn) < NUM) begin
      rdData = value[arIdxIn];
      rdResp = RESP_OKAY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      awHeld_q <= 1'b0;
      wHeld_q  <= 1'b0;
      awIdx_q  <= '0;
      wData_q  <= '0;
      wStrb_q  <= '0;
      bValid_q <= 1'b0;
      bResp_q  <= '0;
      rValid_q <= 1'b0;
      rResp_q  <= '0;
      rData_q  <= '0;
      pulse_q  <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < NUM; i++) reg_q[i] <= (MODE[i] == MODE_RW) ? INIT[i] : '0;
    end else begin
      reg_q    <= reg_d;
      pulse_q  <= pulse_d;
      irq_q    <= irq_d;
      awHeld_q <= awHave && !wrExec;
      wHeld_q  <= wHave && !wrExec;
      if (awHs) awIdx_q <= awIdxIn;
      if (wHs) begin
        wData_q <= s_axi4l_wdata;
        wStrb_q <= s_axi4l_wstrb;
      end
      if (wrExec) begin
        bValid_q <= 1'b1;
        bResp_q  <= wrOk ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi4l_bready) begin
        bValid_q <= 1'b0;
      end
      if (arHs) begin
        rValid_q <= 1'b1;
        rData_q  <= rdData;
        rResp_q  <= rdResp;
      end else if (s_axi4l_rready) begin
        rValid_q <= 1'b0;
      end
    end
  end

  assign s_axi4l_bvalid = bValid_q;
  assign s_axi4l_bresp  = bResp_q;
  assign s_axi4l_rvalid = rValid_q;
  assign s_axi4l_rdata  = rData_q;
  assign s_axi4l_rresp  = rResp_q;
  assign pulse          = pulse_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_jelly3_axi4l_register_mode.sv
// Scoreboard bench for jelly3_axi4l_register_mode: expected B/R responses are
// queued when a transaction is issued and checked when the handshake occurs.
module tb_jelly3_axi4l_register_mode;

  localparam int NUM       = 6;
  localparam int DATA_BITS = 32;
  localparam int ADDR_BITS = 40;
  localparam logic [NUM-1:0][1:0] MODE = {2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};
  localparam logic [NUM-1:0][DATA_BITS-1:0] INIT =
    {32'h0, 32'h0000_00A5, 32'h0, 32'h0, 32'h0, 32'h1234_5678};

  logic                          reset = 1'b1;
  logic                          clk   = 1'b0;
  logic [ADDR_BITS-1:0]          awaddr = '0, araddr = '0;
  logic                          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic                          bready = 1'b1, rready = 1'b1;
  logic [DATA_BITS-1:0]          wdata = '0;
  logic [3:0]                    wstrb = '0;
  logic                          awready, wready, bvalid, arready, rvalid, irq;
  logic [1:0]                    bresp, rresp;
  logic [DATA_BITS-1:0]          rdata;
  logic [NUM-1:0][DATA_BITS-1:0] value, pulse;
  logic [NUM-1:0][DATA_BITS-1:0] roValue = '0;
  logic [NUM-1:0][DATA_BITS-1:0] w1cSet  = '0;

  int         testsRun    = 0;
  int         testsFailed = 0;
  logic [1:0] expB[$];
  logic [33:0] expR[$];
  logic [33:0] rExp;

  jelly3_axi4l_register_mode #(
    .NUM(NUM), .DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS), .MODE(MODE), .INIT(INIT)
  ) dut (
    .reset(reset), .clk(clk),
    .s_axi4l_awaddr(awaddr), .s_axi4l_awprot(3'd0), .s_axi4l_awvalid(awvalid), .s_axi4l_awready(awready),
    .s_axi4l_wdata(wdata), .s_axi4l_wstrb(wstrb), .s_axi4l_wvalid(wvalid), .s_axi4l_wready(wready),
    .s_axi4l_bresp(bresp), .s_axi4l_bvalid(bvalid), .s_axi4l_bready(bready),
    .s_axi4l_araddr(araddr), .s_axi4l_arprot(3'd0), .s_axi4l_arvalid(arvalid), .s_axi4l_arready(arready),
    .s_axi4l_rdata(rdata), .s_axi4l_rresp(rresp), .s_axi4l_rvalid(rvalid), .s_axi4l_rready(rready),
    .value(value), .ro_value(roValue), .w1c_set(w1cSet), .pulse(pulse), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Responses are compared at the negedge before the handshake edge.
  always @(negedge clk) begin
    if (!reset && bvalid && bready) begin
      if (expB.size() == 0) checkOutput("bUnexpected", 64'(bvalid), 64'd0);
      else checkOutput("bresp", 64'(bresp), 64'(expB.pop_front()));
    end
    if (!reset && rvalid && rready) begin
      if (expR.size() == 0) checkOutput("rUnexpected", 64'(rvalid), 64'd0);
      else begin
        rExp = expR.pop_front();
        checkOutput("rdata", 64'(rdata), 64'(rExp[31:0]));
        checkOutput("rresp", 64'(rresp), 64'(rExp[33:32]));
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sendAw(input logic [ADDR_BITS-1:0] addr);
    int n = 0;
    awaddr  = addr;
    awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!awready) checkOutput("awTimeout", 64'(awready), 64'd1);
    nextCycle();
    awvalid = 1'b0;
  endtask

  task automatic sendW(input logic [31:0] data, input logic [3:0] strb);
    int n = 0;
    wdata  = data;
    wstrb  = strb;
    wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!wready) checkOutput("wTimeout", 64'(wready), 64'd1);
    nextCycle();
    wvalid = 1'b0;
  endtask

  task automatic sendAr(input logic [ADDR_BITS-1:0] addr);
    int n = 0;
    araddr  = addr;
    arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!arready) checkOutput("arTimeout", 64'(arready), 64'd1);
    nextCycle();
    arvalid = 1'b0;
  endtask

  task automatic applyStimulusWrite(input logic [ADDR_BITS-1:0] addr, input logic [31:0] data,
                                    input logic [3:0] strb, input logic [1:0] resp);
    expB.push_back(resp);
    fork
      sendAw(addr);
      sendW(data, strb);
    join
  endtask

  task automatic applyStimulusRead(input logic [ADDR_BITS-1:0] addr, input logic [31:0] data,
                                   input logic [1:0] resp);
    expR.push_back({resp, data});
    sendAr(addr);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < NUM; i++) roValue[i] = 32'h5A5A_0000 | 32'(i);
    roValue[1] = 32'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("awreadyInReset", 64'(awready), 64'd0);
    checkOutput("arreadyInReset", 64'(arready), 64'd0);
    nextCycle();
    reset = 1'b0;
    @(negedge clk);
    checkOutput("resetValue0", 64'(value[0]), 64'h1234_5678);
    checkOutput("resetValue4", 64'(value[4]), 64'h0000_00A5);
    checkOutput("resetValue2", 64'(value[2]), 64'd0);
    checkOutput("resetIrq", 64'(irq), 64'd0);
    checkOutput("resetBvalid", 64'(bvalid), 64'd0);
    checkOutput("resetRvalid", 64'(rvalid), 64'd0);
    checkOutput("resetRdata", 64'(rdata), 64'd0);
    nextCycle();

    applyStimulusRead(40'h00, 32'h1234_5678, 2'b00);

    // Split write with B back-pressure.
    bready = 1'b0;
    expB.push_back(2'b00);
    sendAw(40'h00);
    @(negedge clk);
    checkOutput("bvalidBeforeW", 64'(bvalid), 64'd0);
    nextCycle();
    repeat (2) nextCycle();
    sendW(32'hAABB_CCDD, 4'b0101);
    @(negedge clk);
    checkOutput("strbWrite", 64'(value[0]), 64'h12BB_56DD);
    for (int c = 0; c < 4; c++) begin
      checkOutput("bvalidHeld", 64'(bvalid), 64'd1);
      checkOutput("brespHeld", 64'(bresp), 64'd0);
      @(negedge clk);
    end
    nextCycle();
    bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("bvalidDropped", 64'(bvalid), 64'd0);
    nextCycle();

    // W1C register 2.
    w1cSet[2] = 32'h0000_0011;
    nextCycle();
    w1cSet[2] = '0;
    @(negedge clk);
    checkOutput("w1cSet", 64'(value[2]), 64'h11);
    @(negedge clk);
    checkOutput("irqSet", 64'(irq), 64'd1);
    nextCycle();
    w1cSet[2] = 32'h0000_0001;
    applyStimulusWrite(40'h08, 32'h0000_0001, 4'hF, 2'b00);
    w1cSet[2] = '0;
    @(negedge clk);
    checkOutput("w1cSetWins", 64'(value[2]), 64'h11);
    nextCycle();
    applyStimulusWrite(40'h08, 32'h0000_0011, 4'hF, 2'b00);
    @(negedge clk);
    checkOutput("w1cClear", 64'(value[2]), 64'd0);
    @(negedge clk);
    checkOutput("irqClear", 64'(irq), 64'd0);
    nextCycle();

    // PULSE register 3.
    applyStimulusWrite(40'h0C, 32'h8000_0001, 4'hF, 2'b00);
    @(negedge clk);
    checkOutput("pulseHigh", 64'(pulse[3]), 64'h8000_0001);
    @(negedge clk);
    checkOutput("pulseLow", 64'(pulse[3]), 64'd0);
    checkOutput("pulseValue", 64'(value[3]), 64'd0);
    nextCycle();
    applyStimulusRead(40'h0C, 32'h0, 2'b00);

    // RO register 1 and unmapped index 6.
    applyStimulusWrite(40'h04, 32'h0000_1234, 4'hF, 2'b00);
    @(negedge clk);
    checkOutput("roValue", 64'(value[1]), 64'hDEAD_BEEF);
    nextCycle();
    applyStimulusRead(40'h04, 32'hDEAD_BEEF, 2'b00);
    applyStimulusWrite(40'h18, 32'hFFFF_FFFF, 4'hF, 2'b10);
    applyStimulusRead(40'h18, 32'h0, 2'b10);
    @(negedge clk);
    checkOutput("unmappedKeeps0", 64'(value[0]), 64'h12BB_56DD);
    checkOutput("unmappedKeeps4", 64'(value[4]), 64'h0000_00A5);
    nextCycle();

    // Same-cycle read returns the pre-write contents.
    fork
      applyStimulusWrite(40'h10, 32'h0000_0055, 4'hF, 2'b00);
      applyStimulusRead(40'h10, 32'h0000_00A5, 2'b00);
    join
    @(negedge clk);
    checkOutput("rwValue4", 64'(value[4]), 64'h55);
    nextCycle();

    // Reset aborts a held AW; the later transaction completes normally.
    sendAw(40'h00);
    nextCycle();
    reset = 1'b1;
    repeat (2) nextCycle();
    reset = 1'b0;
    sendW(32'hCAFE_F00D, 4'hF);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkOutput("abortNoB", 64'(bvalid), 64'd0);
    end
    checkOutput("abortValue0", 64'(value[0]), 64'h1234_5678);
    nextCycle();
    expB.push_back(2'b00);
    sendAw(40'h00);
    @(negedge clk);
    checkOutput("postResetWrite", 64'(value[0]), 64'hCAFE_F00D);

    repeat (5) @(negedge clk);
    checkOutput("bPending", 64'(expB.size()), 64'd0);
    checkOutput("rPending", 64'(expR.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
